hazard_ctrl: RTL

//  Hazard/forwarding controller for the 3-stage (D, X, MW) core; sequences regfile-read forwarding.

---
 rtl/hazard_ctrl_pkg.sv | 31 +++
 rtl/hazard_ctrl_reg_use_decode.sv | 46 ++++
 rtl/opcode.vh | 14 +
 rtl/hazard_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: shadow-register records and per-cycle action.
package hazard_ctrl_pkg;
  `include "opcode.vh"

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } x_shadow_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
  } mw_shadow_t;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_STALL,
    ACT_ADVANCE
  } action_t;

  // A producer hits a consumer source when it really writes a nonzero rd that the consumer reads.
  function automatic logic src_hit(input logic v, input logic we, input logic [4:0] rd,
                                   input logic uses, input logic [4:0] rs);
    return v & we & (rd != 5'd0) & uses & (rd == rs);
  endfunction
endpackage

// File: rtl/hazard_ctrl_reg_use_decode.sv
// Register-usage decode of the instruction in D; purely combinational, zero latency.
module reg_use_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        valid,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_load
);
  logic [6:0] opc;
  logic       unused_bits;

  assign opc         = inst[6:0];
  assign rs1         = inst[19:15];
  assign rs2         = inst[24:20];
  assign rd          = inst[11:7];
  assign unused_bits = ^{inst[31:25], inst[13:12]};

  always_comb begin
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: uses_rs1 = 1'b0;
      // CSR immediate forms carry a zimm in the rs1 field
      OPC_CSR: uses_rs1 = ~inst[14];
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_ARI_I, OPC_ARI_R: uses_rs1 = 1'b1;
      default: uses_rs1 = 1'b1;
    endcase
    uses_rs2  = (opc == OPC_ARI_R) | (opc == OPC_STORE) | (opc == OPC_BRANCH);
    writes_rd = (opc != OPC_STORE) & (opc != OPC_BRANCH) & (rd != 5'd0);
    is_load   = (opc == OPC_LOAD);
    if (!valid) begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      is_load   = 1'b0;
    end
  end
endmodule

// File: rtl/opcode.vh
// Base-ISA major opcodes (inst[6:0]) shared by every decoder in the core.
`ifndef OPCODE_VH
`define OPCODE_VH
localparam logic [6:0] OPC_LUI    = 7'b0110111;
localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
localparam logic [6:0] OPC_JAL    = 7'b1101111;
localparam logic [6:0] OPC_JALR   = 7'b1100111;
localparam logic [6:0] OPC_BRANCH = 7'b1100011;
localparam logic [6:0] OPC_LOAD   = 7'b0000011;
localparam logic [6:0] OPC_STORE  = 7'b0100011;
localparam logic [6:0] OPC_ARI_I  = 7'b0010011;
localparam logic [6:0] OPC_ARI_R  = 7'b0110011;
localparam logic [6:0] OPC_CSR    = 7'b1110011;
`endif

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding control for the D/X/MW pipe: combinational stall/bubble/wb2d, registered fwd_x.
// Priority rst > mem_busy > flush > load-use > advance; load-use costs one stall cycle.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      d_inst,
  input  logic             d_valid,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             wb2d_a,
  output logic             wb2d_b,
  output logic             fwd_x_a,
  output logic             fwd_x_b,
  output logic             stall_f,
  output logic             bubble_x,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_freeze
);
  logic [4:0] rs1, rs2, rd;
  logic       uses_rs1, uses_rs2, writes_rd, is_load;

  reg_use_decode u_dec (
    .inst      (d_inst),
    .valid     (d_valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load)
  );

  x_shadow_t  x_q;
  mw_shadow_t mw_q;
  logic       fwd_a_q, fwd_b_q;
  logic       load_use;
  action_t    act;

  assign load_use = x_q.ld & (src_hit(x_q.v, x_q.we, x_q.rd, uses_rs1, rs1) |
                              src_hit(x_q.v, x_q.we, x_q.rd, uses_rs2, rs2));

  always_comb begin
    act      = ACT_ADVANCE;
    stall_f  = 1'b0;
    bubble_x = 1'b0;
    if (rst) begin
      act = ACT_RESET;
    end else if (mem_busy) begin
      act     = ACT_FREEZE;
      stall_f = 1'b1;
    end else if (flush) begin
      act      = ACT_FLUSH;
      bubble_x = 1'b1;
    end else if (load_use) begin
      act      = ACT_STALL;
      stall_f  = 1'b1;
      bubble_x = 1'b1;
    end
  end

  // MW->D bypass reads the regfile-write record directly; gated so reset drives it low
  assign wb2d_a = ~rst & src_hit(mw_q.v, mw_q.we, mw_q.rd, uses_rs1, rs1);
  assign wb2d_b = ~rst & src_hit(mw_q.v, mw_q.we, mw_q.rd, uses_rs2, rs2);

  assign fwd_x_a = fwd_a_q;
  assign fwd_x_b = fwd_b_q;

  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        x_q     <= '0;
        mw_q    <= '0;
        fwd_a_q <= 1'b0;
        fwd_b_q <= 1'b0;
      end
      ACT_FREEZE: begin
        x_q     <= x_q;
        mw_q    <= mw_q;
        fwd_a_q <= fwd_a_q;
        fwd_b_q <= fwd_b_q;
      end
      ACT_FLUSH, ACT_STALL: begin
        mw_q    <= '{v: x_q.v, rd: x_q.rd, we: x_q.we};
        x_q     <= '0;
        fwd_a_q <= 1'b0;
        fwd_b_q <= 1'b0;
      end
      default: begin
        mw_q    <= '{v: x_q.v, rd: x_q.rd, we: x_q.we};
        x_q     <= '{v: d_valid, rd: rd, we: writes_rd, ld: is_load};
        // loads never reach this path with a matching source, but their data is not ready in X
        fwd_a_q <= ~x_q.ld & src_hit(x_q.v, x_q.we, x_q.rd, uses_rs1, rs1);
        fwd_b_q <= ~x_q.ld & src_hit(x_q.v, x_q.we, x_q.rd, uses_rs2, rs2);
      end
    endcase
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_stall  <= '0;
      cnt_flush  <= '0;
      cnt_freeze <= '0;
    end else begin
      if (act == ACT_STALL && cnt_stall != CNT_MAX) cnt_stall <= cnt_stall + CNT_ONE;
      if (act == ACT_FLUSH && cnt_flush != CNT_MAX) cnt_flush <= cnt_flush + CNT_ONE;
      if (act == ACT_FREEZE && cnt_freeze != CNT_MAX) cnt_freeze <= cnt_freeze + CNT_ONE;
    end
  end
endmodule
